// File: rtl/hsv_core_commit_pkg.sv
// Commit-stage types: per-unit result payload, unit encoding, regfile helpers.
// Latency: n/a (types only). Backpressure: n/a.
package hsv_core_commit_pkg;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] word_t;
    typedef logic [31:0] reg_mask_t;

    typedef struct packed {
        reg_addr_t rd_addr;
        logic      rd_write;
        word_t     rd_value;
    } commit_data_t;

    typedef enum logic [1:0] {
        ALU         = 2'd0,
        BRANCH      = 2'd1,
        CTRL_STATUS = 2'd2,
        MEM         = 2'd3
    } commit_unit_t;

    localparam int COMMIT_UNITS = 4;

    function automatic reg_mask_t rd_onehot(input reg_addr_t addr);
        return reg_mask_t'(1) << addr;
    endfunction

endpackage

// File: rtl/hsv_core_commit_if.sv
// Result handshakes from the four units plus the regfile/retire side of commit.
// Latency: n/a (wiring). Backpressure: per-unit valid/ready, ready driven by commit.
interface hsv_core_commit_if
    import hsv_core_commit_pkg::*;
#(
    parameter int INSTRET_W = 64
);
    logic                 flush_req;
    logic                 flush_ack;
    commit_data_t         alu_result;
    logic                 alu_valid_i;
    logic                 alu_ready_o;
    commit_data_t         branch_result;
    logic                 branch_valid_i;
    logic                 branch_ready_o;
    commit_data_t         ctrl_status_result;
    logic                 ctrl_status_valid_i;
    logic                 ctrl_status_ready_o;
    commit_data_t         mem_result;
    logic                 mem_valid_i;
    logic                 mem_ready_o;
    reg_addr_t            wr_addr;
    word_t                wr_data;
    logic                 wr_en;
    reg_mask_t            rd_release;
    logic                 retire_o;
    logic [INSTRET_W-1:0] instret;

    modport slave (
        input  flush_req,
        input  alu_result, alu_valid_i,
        input  branch_result, branch_valid_i,
        input  ctrl_status_result, ctrl_status_valid_i,
        input  mem_result, mem_valid_i,
        output alu_ready_o, branch_ready_o, ctrl_status_ready_o, mem_ready_o,
        output flush_ack, wr_addr, wr_data, wr_en, rd_release, retire_o, instret
    );

    modport master (
        output flush_req,
        output alu_result, alu_valid_i,
        output branch_result, branch_valid_i,
        output ctrl_status_result, ctrl_status_valid_i,
        output mem_result, mem_valid_i,
        input  alu_ready_o, branch_ready_o, ctrl_status_ready_o, mem_ready_o,
        input  flush_ack, wr_addr, wr_data, wr_en, rd_release, retire_o, instret
    );

endinterface

// File: rtl/hsv_core_commit_arbiter.sv
// Four-way commit arbiter: combinational grant searched from a registered pointer.
// Latency: grant same cycle. Backpressure: losers see no grant and must hold valid.
module hsv_core_commit_arbiter
    import hsv_core_commit_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic                    clk_core,
    input  logic                    rst_core_n,
    input  logic [COMMIT_UNITS-1:0] valid,
    input  logic                    advance,
    input  logic                    flush,
    output logic [COMMIT_UNITS-1:0] grant,
    output commit_unit_t            unit
);

    logic [1:0] ptr;
    logic [1:0] idx;
    logic       found;

    always_comb begin
        grant = '0;
        unit  = ALU;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < COMMIT_UNITS; i++) begin
            idx = ptr + 2'(i);
            if (!found && !flush && valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                unit       = commit_unit_t'(idx);
            end
        end
    end

    // Pointer moves just past the winner so every unit gets a turn.
    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            ptr <= '0;
        end else if (flush) begin
            ptr <= '0;
        end else if (ROUND_ROBIN && advance) begin
            ptr <= 2'(unit) + 2'd1;
        end
    end

endmodule

// File: rtl/hsv_core_commit.sv
// Commit stage: picks one unit result per cycle, writes regfile, releases rd, counts retires.
// Latency: 1 cycle handshake-to-write. Backpressure: one ready per cycle, none while flushing.
module hsv_core_commit
    import hsv_core_commit_pkg::*;
#(
    parameter int INSTRET_W   = 64,
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic               clk_core,
    input  logic               rst_core_n,
    hsv_core_commit_if.slave   bus
);

    logic [COMMIT_UNITS-1:0] valid;
    logic [COMMIT_UNITS-1:0] grant;
    logic [COMMIT_UNITS-1:0] ready;
    commit_unit_t            unit;
    commit_data_t            sel;
    logic                    handshake;
    logic                    wr_fire;

    logic                 wr_en_q;
    reg_addr_t            wr_addr_q;
    word_t                wr_data_q;
    reg_mask_t            rd_release_q;
    logic                 retire_q;
    logic                 flush_ack_q;
    logic [INSTRET_W-1:0] instret_q;

    assign valid = {bus.mem_valid_i, bus.ctrl_status_valid_i,
                    bus.branch_valid_i, bus.alu_valid_i};

    hsv_core_commit_arbiter #(
        .ROUND_ROBIN (ROUND_ROBIN)
    ) u_arbiter (
        .clk_core   (clk_core),
        .rst_core_n (rst_core_n),
        .valid      (valid),
        .advance    (handshake),
        .flush      (bus.flush_req),
        .grant      (grant),
        .unit       (unit)
    );

    assign ready     = grant & {COMMIT_UNITS{~bus.flush_req}};
    assign handshake = |ready;

    assign bus.alu_ready_o         = ready[ALU];
    assign bus.branch_ready_o      = ready[BRANCH];
    assign bus.ctrl_status_ready_o = ready[CTRL_STATUS];
    assign bus.mem_ready_o         = ready[MEM];

    always_comb begin
        sel = bus.alu_result;
        case (unit)
            ALU:         sel = bus.alu_result;
            BRANCH:      sel = bus.branch_result;
            CTRL_STATUS: sel = bus.ctrl_status_result;
            MEM:         sel = bus.mem_result;
            default:     sel = bus.alu_result;
        endcase
    end

    // x0 is never written and never held in the hazard mask.
    assign wr_fire = sel.rd_write && (sel.rd_addr != '0);

    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            rd_release_q <= '0;
            retire_q     <= 1'b0;
            flush_ack_q  <= 1'b0;
            instret_q    <= '0;
        end else begin
            wr_en_q      <= handshake && wr_fire;
            rd_release_q <= (handshake && wr_fire) ? rd_onehot(sel.rd_addr) : '0;
            retire_q     <= handshake;
            flush_ack_q  <= bus.flush_req;
            if (handshake) begin
                wr_addr_q <= sel.rd_addr;
                wr_data_q <= sel.rd_value;
                instret_q <= instret_q + INSTRET_W'(1);
            end
        end
    end

    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.rd_release = rd_release_q;
    assign bus.retire_o   = retire_q;
    assign bus.flush_ack  = flush_ack_q;
    assign bus.instret    = instret_q;

endmodule

// File: tb/tb_hsv_core_commit.sv
// Directed bench for hsv_core_commit: round-robin instance plus a narrow-counter fixed-priority instance.
module tb_hsv_core_commit;
    import hsv_core_commit_pkg::*;

    logic clk_core = 1'b0;
    logic rst_core_n;
    always #5 clk_core = ~clk_core;

    hsv_core_commit_if #(.INSTRET_W(64)) bus ();
    hsv_core_commit_if #(.INSTRET_W(4))  bus2 ();

    hsv_core_commit #(.INSTRET_W(64), .ROUND_ROBIN(1'b1)) dut (
        .clk_core   (clk_core),
        .rst_core_n (rst_core_n),
        .bus        (bus)
    );

    hsv_core_commit #(.INSTRET_W(4), .ROUND_ROBIN(1'b0)) dut_fixed (
        .clk_core   (clk_core),
        .rst_core_n (rst_core_n),
        .bus        (bus2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic commit_data_t mk(input logic [4:0] a, input logic w, input logic [31:0] v);
        commit_data_t d;
        d.rd_addr  = a;
        d.rd_write = w;
        d.rd_value = v;
        return d;
    endfunction

    function automatic logic [3:0] readys();
        return {bus.mem_ready_o, bus.ctrl_status_ready_o, bus.branch_ready_o, bus.alu_ready_o};
    endfunction

    function automatic logic [3:0] readys2();
        return {bus2.mem_ready_o, bus2.ctrl_status_ready_o, bus2.branch_ready_o, bus2.alu_ready_o};
    endfunction

    task automatic step();
        @(posedge clk_core);
        #1;
    endtask

    task automatic clear_inputs();
        bus.flush_req = 1'b0;
        bus.alu_valid_i = 1'b0;         bus.alu_result = '0;
        bus.branch_valid_i = 1'b0;      bus.branch_result = '0;
        bus.ctrl_status_valid_i = 1'b0; bus.ctrl_status_result = '0;
        bus.mem_valid_i = 1'b0;         bus.mem_result = '0;
        bus2.flush_req = 1'b0;
        bus2.alu_valid_i = 1'b0;         bus2.alu_result = '0;
        bus2.branch_valid_i = 1'b0;      bus2.branch_result = '0;
        bus2.ctrl_status_valid_i = 1'b0; bus2.ctrl_status_result = '0;
        bus2.mem_valid_i = 1'b0;         bus2.mem_result = '0;
    endtask

    task automatic pulse_reset();
        rst_core_n = 1'b0;
        #1;
        rst_core_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (bus.wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en got %0b want 0", bus.wr_en); end
        n_cmp++; if (bus.wr_addr !== 5'd0) begin n_bad++; $display("FAIL reset_wr_addr got %0d want 0", bus.wr_addr); end
        n_cmp++; if (bus.wr_data !== 32'd0) begin n_bad++; $display("FAIL reset_wr_data got %h want 0", bus.wr_data); end
        n_cmp++; if (bus.rd_release !== 32'd0) begin n_bad++; $display("FAIL reset_rd_release got %h want 0", bus.rd_release); end
        n_cmp++; if (bus.retire_o !== 1'b0) begin n_bad++; $display("FAIL reset_retire got %0b want 0", bus.retire_o); end
        n_cmp++; if (bus.instret !== 64'd0) begin n_bad++; $display("FAIL reset_instret got %0d want 0", bus.instret); end
        n_cmp++; if (bus.flush_ack !== 1'b0) begin n_bad++; $display("FAIL reset_flush_ack got %0b want 0", bus.flush_ack); end
        n_cmp++; if (readys() !== 4'b0000) begin n_bad++; $display("FAIL reset_ready got %b want 0000", readys()); end
        n_cmp++; if (bus2.instret !== 4'd0) begin n_bad++; $display("FAIL reset_instret2 got %0d want 0", bus2.instret); end
        @(negedge clk_core);
        rst_core_n = 1'b1;
        step();
    endtask

    task automatic test_single_alu();
        bus.alu_result = mk(5'd5, 1'b1, 32'hDEADBEEF);
        bus.alu_valid_i = 1'b1;
        #1;
        n_cmp++; if (readys() !== 4'b0001) begin n_bad++; $display("FAIL single_ready got %b want 0001", readys()); end
        step();
        bus.alu_valid_i = 1'b0;
        n_cmp++; if (bus.wr_en !== 1'b1) begin n_bad++; $display("FAIL single_wr_en got %0b want 1", bus.wr_en); end
        n_cmp++; if (bus.wr_addr !== 5'd5) begin n_bad++; $display("FAIL single_wr_addr got %0d want 5", bus.wr_addr); end
        n_cmp++; if (bus.wr_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL single_wr_data got %h want deadbeef", bus.wr_data); end
        n_cmp++; if (bus.rd_release !== 32'h0000_0020) begin n_bad++; $display("FAIL single_rd_release got %h want 00000020", bus.rd_release); end
        n_cmp++; if (bus.retire_o !== 1'b1) begin n_bad++; $display("FAIL single_retire got %0b want 1", bus.retire_o); end
        n_cmp++; if (bus.instret !== 64'd1) begin n_bad++; $display("FAIL single_instret got %0d want 1", bus.instret); end
        step();
        n_cmp++; if (bus.wr_en !== 1'b0) begin n_bad++; $display("FAIL idle_wr_en got %0b want 0", bus.wr_en); end
        n_cmp++; if (bus.retire_o !== 1'b0) begin n_bad++; $display("FAIL idle_retire got %0b want 0", bus.retire_o); end
        n_cmp++; if (bus.rd_release !== 32'd0) begin n_bad++; $display("FAIL idle_rd_release got %h want 0", bus.rd_release); end
        n_cmp++; if (bus.wr_addr !== 5'd5) begin n_bad++; $display("FAIL idle_wr_addr_hold got %0d want 5", bus.wr_addr); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        pulse_reset();
        bus.alu_result         = mk(5'd1, 1'b1, 32'h100);
        bus.branch_result      = mk(5'd2, 1'b1, 32'h101);
        bus.ctrl_status_result = mk(5'd3, 1'b1, 32'h102);
        bus.mem_result         = mk(5'd4, 1'b1, 32'h103);
        bus.alu_valid_i = 1'b1; bus.branch_valid_i = 1'b1;
        bus.ctrl_status_valid_i = 1'b1; bus.mem_valid_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            #1;
            n_cmp++; if (readys() !== exp_g) begin n_bad++; $display("FAIL rr_grant[%0d] got %b want %b", k, readys(), exp_g); end
            step();
            n_cmp++; if (bus.wr_addr !== 5'((k % 4) + 1)) begin n_bad++; $display("FAIL rr_wr_addr[%0d] got %0d want %0d", k, bus.wr_addr, (k % 4) + 1); end
            n_cmp++; if (bus.wr_data !== 32'(32'h100 + (k % 4))) begin n_bad++; $display("FAIL rr_wr_data[%0d] got %h want %h", k, bus.wr_data, 32'h100 + (k % 4)); end
            n_cmp++; if (bus.instret !== 64'(k + 1)) begin n_bad++; $display("FAIL rr_instret[%0d] got %0d want %0d", k, bus.instret, k + 1); end
        end
        clear_inputs();
    endtask

    task automatic test_no_write();
        bus.branch_result = mk(5'd7, 1'b0, 32'h55);
        bus.alu_result    = mk(5'd0, 1'b1, 32'h66);
        bus.branch_valid_i = 1'b1;
        bus.alu_valid_i    = 1'b1;
        #1;
        n_cmp++; if (readys() !== 4'b0010) begin n_bad++; $display("FAIL nw_grant0 got %b want 0010", readys()); end
        step();
        bus.branch_valid_i = 1'b0;
        n_cmp++; if (bus.wr_en !== 1'b0) begin n_bad++; $display("FAIL nw_wr_en0 got %0b want 0", bus.wr_en); end
        n_cmp++; if (bus.rd_release !== 32'd0) begin n_bad++; $display("FAIL nw_release0 got %h want 0", bus.rd_release); end
        n_cmp++; if (bus.retire_o !== 1'b1) begin n_bad++; $display("FAIL nw_retire0 got %0b want 1", bus.retire_o); end
        n_cmp++; if (bus.instret !== 64'd6) begin n_bad++; $display("FAIL nw_instret0 got %0d want 6", bus.instret); end
        #1;
        n_cmp++; if (readys() !== 4'b0001) begin n_bad++; $display("FAIL nw_grant1 got %b want 0001", readys()); end
        step();
        bus.alu_valid_i = 1'b0;
        n_cmp++; if (bus.wr_en !== 1'b0) begin n_bad++; $display("FAIL nw_wr_en1 got %0b want 0", bus.wr_en); end
        n_cmp++; if (bus.rd_release !== 32'd0) begin n_bad++; $display("FAIL nw_release1 got %h want 0", bus.rd_release); end
        n_cmp++; if (bus.retire_o !== 1'b1) begin n_bad++; $display("FAIL nw_retire1 got %0b want 1", bus.retire_o); end
        n_cmp++; if (bus.instret !== 64'd7) begin n_bad++; $display("FAIL nw_instret1 got %0d want 7", bus.instret); end
        step();
        n_cmp++; if (bus.retire_o !== 1'b0) begin n_bad++; $display("FAIL nw_retire_idle got %0b want 0", bus.retire_o); end
    endtask

    task automatic test_flush();
        bus.alu_result = mk(5'd3, 1'b1, 32'h77);
        bus.alu_valid_i = 1'b1;
        step();
        bus.alu_valid_i = 1'b0;
        bus.flush_req   = 1'b1;
        bus.mem_result  = mk(5'd4, 1'b1, 32'h88);
        bus.mem_valid_i = 1'b1;
        #1;
        n_cmp++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd3) begin n_bad++; $display("FAIL fl_prior_write got en=%0b addr=%0d want en=1 addr=3", bus.wr_en, bus.wr_addr); end
        n_cmp++; if (readys() !== 4'b0000) begin n_bad++; $display("FAIL fl_ready got %b want 0000", readys()); end
        step();
        n_cmp++; if (bus.wr_en !== 1'b0) begin n_bad++; $display("FAIL fl_wr_en got %0b want 0", bus.wr_en); end
        n_cmp++; if (bus.retire_o !== 1'b0) begin n_bad++; $display("FAIL fl_retire got %0b want 0", bus.retire_o); end
        n_cmp++; if (bus.flush_ack !== 1'b1) begin n_bad++; $display("FAIL fl_ack got %0b want 1", bus.flush_ack); end
        n_cmp++; if (bus.instret !== 64'd8) begin n_bad++; $display("FAIL fl_instret got %0d want 8", bus.instret); end
        bus.flush_req = 1'b0;
        bus.alu_result = mk(5'd10, 1'b1, 32'hAA);
        bus.alu_valid_i = 1'b1;
        #1;
        n_cmp++; if (readys() !== 4'b0001) begin n_bad++; $display("FAIL fl_ptr_reset got %b want 0001", readys()); end
        step();
        bus.alu_valid_i = 1'b0;
        n_cmp++; if (bus.flush_ack !== 1'b0) begin n_bad++; $display("FAIL fl_ack_fall got %0b want 0", bus.flush_ack); end
        n_cmp++; if (bus.wr_addr !== 5'd10) begin n_bad++; $display("FAIL fl_alu_addr got %0d want 10", bus.wr_addr); end
        n_cmp++; if (bus.instret !== 64'd9) begin n_bad++; $display("FAIL fl_instret9 got %0d want 9", bus.instret); end
        #1;
        n_cmp++; if (readys() !== 4'b1000) begin n_bad++; $display("FAIL fl_mem_grant got %b want 1000", readys()); end
        step();
        bus.mem_valid_i = 1'b0;
        n_cmp++; if (bus.wr_addr !== 5'd4 || bus.wr_data !== 32'h88) begin n_bad++; $display("FAIL fl_mem_write got %0d/%h want 4/00000088", bus.wr_addr, bus.wr_data); end
        n_cmp++; if (bus.rd_release !== 32'h0000_0010) begin n_bad++; $display("FAIL fl_mem_release got %h want 00000010", bus.rd_release); end
        n_cmp++; if (bus.instret !== 64'd10) begin n_bad++; $display("FAIL fl_instret10 got %0d want 10", bus.instret); end
    endtask

    task automatic test_reset_mid();
        bus.alu_result = mk(5'd9, 1'b1, 32'h99);
        bus.alu_valid_i = 1'b1;
        step();
        bus.alu_valid_i = 1'b0;
        n_cmp++; if (bus.wr_en !== 1'b1) begin n_bad++; $display("FAIL rm_pre_wr_en got %0b want 1", bus.wr_en); end
        rst_core_n = 1'b0;
        #1;
        n_cmp++; if (bus.wr_en !== 1'b0) begin n_bad++; $display("FAIL rm_wr_en got %0b want 0", bus.wr_en); end
        n_cmp++; if (bus.retire_o !== 1'b0) begin n_bad++; $display("FAIL rm_retire got %0b want 0", bus.retire_o); end
        n_cmp++; if (bus.instret !== 64'd0) begin n_bad++; $display("FAIL rm_instret got %0d want 0", bus.instret); end
        n_cmp++; if (bus.rd_release !== 32'd0) begin n_bad++; $display("FAIL rm_release got %h want 0", bus.rd_release); end
        #2;
        rst_core_n = 1'b1;
        step();
        n_cmp++; if (bus.wr_en !== 1'b0 || bus.retire_o !== 1'b0) begin n_bad++; $display("FAIL rm_post got en=%0b ret=%0b want 0/0", bus.wr_en, bus.retire_o); end
    endtask

    task automatic test_fixed_wrap();
        bus2.alu_result         = mk(5'd1, 1'b1, 32'h200);
        bus2.branch_result      = mk(5'd2, 1'b1, 32'h201);
        bus2.ctrl_status_result = mk(5'd3, 1'b1, 32'h202);
        bus2.mem_result         = mk(5'd4, 1'b1, 32'h203);
        bus2.alu_valid_i = 1'b1; bus2.branch_valid_i = 1'b1;
        bus2.ctrl_status_valid_i = 1'b1; bus2.mem_valid_i = 1'b1;
        for (int k = 0; k < 17; k++) begin
            #1;
            n_cmp++; if (readys2() !== 4'b0001) begin n_bad++; $display("FAIL fx_grant[%0d] got %b want 0001", k, readys2()); end
            step();
            n_cmp++; if (bus2.instret !== 4'((k + 1) % 16)) begin n_bad++; $display("FAIL fx_instret[%0d] got %0d want %0d", k, bus2.instret, (k + 1) % 16); end
        end
        n_cmp++; if (bus2.wr_addr !== 5'd1) begin n_bad++; $display("FAIL fx_wr_addr got %0d want 1", bus2.wr_addr); end
        clear_inputs();
    endtask

    initial begin
        rst_core_n = 1'b0;
        clear_inputs();
        test_reset();
        test_single_alu();
        test_round_robin();
        test_no_write();
        test_flush();
        test_reset_mid();
        test_fixed_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
